// File: rtl/pattern_scan_pkg.sv
// Shared types for the programmable pattern-scan controller.
package pattern_scan_pkg;

   // Scan controller states; encoding is fixed so software-visible debug reads stay stable.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StArm  = 2'b01,
      StScan = 2'b10,
      StDone = 2'b11
   } scan_state_e;

   // Widest supported pattern and the matching length-field width.
   localparam int unsigned PwMax   = 16;
   localparam int unsigned LenWMax = $clog2(PwMax + 1);

   // Width of a length field able to hold 0..pw.
   function automatic int unsigned len_width(input int unsigned pw);
      return $clog2(pw + 1);
   endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Config/control and serial-input bundle of the pattern-scan controller.
interface pattern_scan_ctrl_if
   import pattern_scan_pkg::*;
#(
   parameter int unsigned PW = 8,
   parameter int unsigned CW = 8
);
   localparam int unsigned LW = len_width(PW);

   logic [PW-1:0] cfg_pattern;
   logic [LW-1:0] cfg_len;
   logic [CW-1:0] cfg_target;
   logic          start;
   logic          abort;
   logic          din_valid;
   logic          din;
   logic          busy;
   logic          match;
   logic [CW-1:0] match_cnt;
   logic          done;

   modport master (
      output cfg_pattern, cfg_len, cfg_target, start, abort, din_valid, din,
      input  busy, match, match_cnt, done
   );

   modport slave (
      input  cfg_pattern, cfg_len, cfg_target, start, abort, din_valid, din,
      output busy, match, match_cnt, done
   );

endinterface

// File: rtl/pattern_match_core.sv
// History shift register, fill counter and length-masked compare.
// Build option OVERLAP_EN: keep history/fill after a hit so overlapping occurrences match.
module pattern_match_core
   import pattern_scan_pkg::*;
#(
   parameter int unsigned PW = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     shift_i,
   input  logic                     din_i,
   input  logic [len_width(PW)-1:0] len_i,
   input  logic [PW-1:0]            pattern_i,
   output logic                     hit_o
);
   localparam int unsigned LW = len_width(PW);

   logic [PW-1:0] hist_q, hist_d, mask;
   logic [LW-1:0] fill_q, fill_d, fill_inc;

   // Next history/fill and the hit decision on the incoming bit.
   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(PW); i++) begin
         mask[i] = (i < int'(len_i));
      end
      fill_inc = (fill_q == LW'(PW)) ? fill_q : fill_q + LW'(1);
      hist_d   = hist_q;
      fill_d   = fill_q;
      hit_o    = 1'b0;
      if (clear_i) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift_i) begin
         hist_d = {hist_q[PW-2:0], din_i};
         fill_d = fill_inc;
         hit_o  = (fill_inc >= len_i) && ((hist_d & mask) == (pattern_i & mask));
`ifndef OVERLAP_EN
         // Non-overlapping: the next hit needs len fresh bits.
         if (hit_o) begin
            fill_d = '0;
         end
`endif
      end
   end

   // History and fill registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Programmable serial-pattern detection controller: FSM, config latch, match counter.
// Build option OVERLAP_EN (see pattern_match_core) selects overlapping detection.
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int unsigned PW = 8,
   parameter int unsigned CW = 8
) (
   input logic                CLK,
   input logic                RST_N,
   pattern_scan_ctrl_if.slave ctrl_if
);
   localparam int unsigned LW = len_width(PW);

   scan_state_e   state_q, state_d;
   logic [PW-1:0] pat_q, pat_d;
   logic [LW-1:0] len_q, len_d, len_clamped;
   logic [CW-1:0] tgt_q, tgt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          match_q, match_d;
   logic          shift, clear, hit;

   assign len_clamped = (ctrl_if.cfg_len == '0 || ctrl_if.cfg_len > LW'(PW)) ?
                        LW'(PW) : ctrl_if.cfg_len;

   // Abort suppresses the shift so an aborted completing bit never hits.
   assign shift = (state_q == StScan) && ctrl_if.din_valid && !ctrl_if.abort;
   assign clear = (state_q == StArm);

   pattern_match_core #(
      .PW(PW)
   ) u_core (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .clear_i  (clear),
      .shift_i  (shift),
      .din_i    (ctrl_if.din),
      .len_i    (len_q),
      .pattern_i(pat_q),
      .hit_o    (hit)
   );

   // Next state, config latch and match counter.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      match_d = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (ctrl_if.start) begin
               state_d = StArm;
               pat_d   = ctrl_if.cfg_pattern;
               len_d   = len_clamped;
               tgt_d   = ctrl_if.cfg_target;
            end
         end
         StArm: begin
            cnt_d   = '0;
            state_d = StScan;
         end
         StScan: begin
            if (hit) begin
               match_d = 1'b1;
               cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
               if (tgt_q != '0 && cnt_d == tgt_q) begin
                  state_d = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (ctrl_if.abort) begin
         state_d = StIdle;
         pat_d   = pat_q;
         len_d   = len_q;
         tgt_d   = tgt_q;
         cnt_d   = cnt_q;
         match_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         pat_q   <= '0;
         len_q   <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
      end
   end

   assign ctrl_if.busy      = (state_q == StArm) || (state_q == StScan);
   assign ctrl_if.done      = (state_q == StDone);
   assign ctrl_if.match     = match_q;
   assign ctrl_if.match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a match-count scoreboard.
module tb_pattern_scan_ctrl;

`ifdef OVERLAP_EN
   localparam bit Overlap = 1'b1;
`else
   localparam bit Overlap = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   exp_q[$];

   // Reference model state.
   logic [7:0] m_hist, m_pat;
   int         m_fill, m_len, m_cnt, m_tgt;
   bit         m_scan = 1'b0;

   pattern_scan_ctrl_if #(.PW(8), .CW(8)) bus ();

   pattern_scan_ctrl #(.PW(8), .CW(8)) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .ctrl_if(bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_bit(input logic b);
      logic [7:0] mk;
      m_hist = {m_hist[6:0], b};
      if (m_fill < 8) m_fill++;
      mk = 8'hFF;
      mk = mk >> (8 - m_len);
      if (m_fill >= m_len && ((m_hist ^ m_pat) & mk) == 8'h00) begin
         if (m_cnt < 255) m_cnt++;
         exp_q.push_back(m_cnt);
         if (!Overlap) m_fill = 0;
         if (m_tgt != 0 && m_cnt == m_tgt) m_scan = 1'b0;
      end
   endtask

   task automatic send(input logic v, input logic b, input logic ab);
      bus.din_valid = v;
      bus.din       = b;
      bus.abort     = ab;
      if (ab) m_scan = 1'b0;
      else if (m_scan && v) model_bit(b);
      @(posedge CLK); #1;
      bus.din_valid = 1'b0;
      bus.din       = 1'b0;
      bus.abort     = 1'b0;
   endtask

   // Start pulse, then one ARM cycle with a valid bit that must be ignored.
   task automatic arm(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
      bus.cfg_pattern = p;
      bus.cfg_len     = l;
      bus.cfg_target  = t;
      bus.start       = 1'b1;
      @(posedge CLK); #1;
      bus.start = 1'b0;
      m_pat  = p;
      m_len  = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
      m_tgt  = int'(t);
      m_hist = 8'h00;
      m_fill = 0;
      m_cnt  = 0;
      m_scan = 1'b1;
      check("busy_in_arm", 32'(bus.busy), 1);
      bus.din_valid = 1'b1;
      bus.din       = 1'b1;
      @(posedge CLK); #1;
      bus.din_valid = 1'b0;
      bus.din       = 1'b0;
   endtask

   // Scoreboard: every match pulse must be expected and carry the expected count.
   always @(negedge CLK) begin
      if (RST_N && bus.match === 1'b1) begin
         check("match_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("match_cnt_at_pulse", 32'(bus.match_cnt), exp_q.pop_front());
      end
   end

   initial begin
      logic [7:0] a5;
      bus.cfg_pattern = 8'h00;
      bus.cfg_len     = 4'd0;
      bus.cfg_target  = 8'h00;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.din_valid   = 1'b0;
      bus.din         = 1'b0;

      // Reset values
      #2;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_match", 32'(bus.match), 0);
      check("rst_cnt", 32'(bus.match_cnt), 0);
      check("rst_done", 32'(bus.done), 0);
      @(negedge CLK) RST_N = 1'b1;
      @(posedge CLK); #1;

      // 101 on 10101, unlimited target; live config changes must not matter
      arm(8'b101, 4'd3, 8'd0);
      bus.cfg_pattern = 8'h00;
      bus.cfg_len     = 4'd1;
      send(1, 1, 0); send(1, 0, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
      send(0, 0, 0);
      check("t1_cnt", 32'(bus.match_cnt), Overlap ? 2 : 1);
      check("t1_pending", 32'(exp_q.size()), 0);
      send(0, 0, 1);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_done", 32'(bus.done), 0);
      check("abort_cnt_held", 32'(bus.match_cnt), Overlap ? 2 : 1);

      // 1101 x2 with target 2 -> DONE; later bits ignored
      arm(8'b1101, 4'd4, 8'd2);
      send(1, 1, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
      send(1, 1, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
      check("t2_done", 32'(bus.done), 1);
      check("t2_busy", 32'(bus.busy), 0);
      check("t2_cnt", 32'(bus.match_cnt), 2);
      send(1, 1, 0); send(1, 1, 0); send(1, 0, 0); send(1, 1, 0);
      check("t2_cnt_hold", 32'(bus.match_cnt), 2);
      check("t2_done_hold", 32'(bus.done), 1);

      // Restart from DONE; invalid cycles carry misleading data
      arm(8'b101, 4'd3, 8'd0);
      check("t3_cnt_cleared", 32'(bus.match_cnt), 0);
      send(1, 1, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 0); send(1, 1, 0);
      send(0, 0, 0);
      check("t3_cnt", 32'(bus.match_cnt), 1);
      check("t3_pending", 32'(exp_q.size()), 0);

      // start in SCAN ignored
      bus.cfg_pattern = 8'hFF;
      bus.start       = 1'b1;
      send(0, 0, 0);
      bus.start = 1'b0;
      check("t4_start_ignored", 32'(bus.match_cnt), 1);
      check("t4_still_busy", 32'(bus.busy), 1);

      // abort on the completing bit
      send(1, 1, 0); send(1, 0, 0); send(1, 1, 1);
      send(0, 0, 0);
      check("t4_busy", 32'(bus.busy), 0);
      check("t4_done", 32'(bus.done), 0);
      check("t4_cnt", 32'(bus.match_cnt), 1);
      check("t4_pending", 32'(exp_q.size()), 0);

      // Asynchronous reset mid-SCAN
      arm(8'b101, 4'd3, 8'd0);
      send(1, 1, 0); send(1, 0, 0); send(1, 1, 0); send(1, 0, 0);
      check("t5_cnt_pre", 32'(bus.match_cnt), 1);
      #3 RST_N = 1'b0;
      m_scan = 1'b0;
      #1;
      check("t5_busy", 32'(bus.busy), 0);
      check("t5_match", 32'(bus.match), 0);
      check("t5_cnt", 32'(bus.match_cnt), 0);
      check("t5_done", 32'(bus.done), 0);
      @(negedge CLK) RST_N = 1'b1;
      @(posedge CLK); #1;
      send(1, 1, 0); send(1, 0, 0); send(1, 1, 0); send(0, 0, 0);
      check("t5_no_scan_cnt", 32'(bus.match_cnt), 0);
      check("t5_no_scan_busy", 32'(bus.busy), 0);

      // cfg_len=0 clamps to full width
      arm(8'hA5, 4'd0, 8'd0);
      a5 = 8'hA5;
      for (int i = 7; i >= 1; i--) send(1, a5[i], 0);
      send(0, 0, 0);
      check("t6_no_early", 32'(bus.match_cnt), 0);
      send(1, a5[0], 0);
      send(0, 0, 0);
      check("t6_cnt", 32'(bus.match_cnt), 1);
      check("final_pending", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
